// File: rtl/z80_bus_pkg.sv
// Shared types for the Z80 external memory bus sequencer: T-state encoding,
// request bundle and the idle level of the active-low strobes.
package z80_bus_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    T1     = 3'd1,
    T2     = 3'd2,
    TW     = 3'd3,
    T3     = 3'd4,
    BUSACK = 3'd5
  } tstate_t;

  typedef struct packed {
    logic        write;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } bus_req_t;

  localparam logic STROBE_INACTIVE = 1'b1;

endpackage

// File: rtl/z80_wait_counter.sv
// Counts TW states of the current M-cycle and flags when MAX_WAIT is reached.
// MAX_WAIT=0 disables the timeout flag entirely.
module z80_wait_counter #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic timeout
);

  localparam int unsigned CW = (MAX_WAIT == 0) ? 1 : $clog2(MAX_WAIT + 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign timeout = (MAX_WAIT != 0) && (count_q == CW'(MAX_WAIT));

endmodule

// File: rtl/z80_mem_cycle_seq.sv
// Z80 memory M-cycle sequencer (T1/T2/TW/T3) with WAIT insertion and timeout.
// Optional bus request/acknowledge handling is enabled by Z80_SEQ_BUSREQ_EN.
module z80_mem_cycle_seq
  import z80_bus_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
`ifdef Z80_SEQ_BUSREQ_EN
  input  logic        busreq_n,
  output logic        busack_n,
`endif
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_dout,
  output logic        bus_doe,
  input  logic [7:0]  bus_din,
  output logic        mreq_n,
  output logic        rd_n,
  output logic        wr_n,
  input  logic        wait_n
);

  tstate_t     state_q, state_d;
  logic        write_q, write_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [7:0]  rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic [15:0] bus_addr_q, bus_addr_d;
  logic [7:0]  bus_dout_q, bus_dout_d;
  logic        bus_doe_q, bus_doe_d;
  logic        mreq_n_q, mreq_n_d;
  logic        rd_n_q, rd_n_d;
  logic        wr_n_q, wr_n_d;

  bus_req_t    req_in;
  logic        handshake;
  logic        cnt_clr, cnt_inc, cnt_timeout;
  logic        bus_grant, bus_release, accept_ok;

  assign req_in    = '{write: req_write, addr: req_addr, wdata: req_wdata};
  assign handshake = req_valid && req_ready_q;

`ifdef Z80_SEQ_BUSREQ_EN
  logic busreq_q;
  logic busack_n_q, busack_n_d;

  // busreq_n is registered so req_ready and the BUSACK decision see the same sample.
  assign bus_grant   = !busreq_q;
  assign bus_release = busreq_q;
  assign accept_ok   = busreq_n;
  assign busack_n_d  = (state_d == BUSACK) ? 1'b0 : STROBE_INACTIVE;

  always_ff @(posedge clk) begin
    if (reset) begin
      busreq_q   <= 1'b1;
      busack_n_q <= STROBE_INACTIVE;
    end else begin
      busreq_q   <= busreq_n;
      busack_n_q <= busack_n_d;
    end
  end

  assign busack_n = busack_n_q;
`else
  assign bus_grant   = 1'b0;
  assign bus_release = 1'b1;
  assign accept_ok   = 1'b1;
`endif

  z80_wait_counter #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_counter (
    .clk     (clk),
    .reset   (reset),
    .clr     (cnt_clr),
    .inc     (cnt_inc),
    .timeout (cnt_timeout)
  );

  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    req_ready_d = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    bus_addr_d  = bus_addr_q;
    bus_dout_d  = bus_dout_q;
    bus_doe_d   = 1'b0;
    mreq_n_d    = STROBE_INACTIVE;
    rd_n_d      = STROBE_INACTIVE;
    wr_n_d      = STROBE_INACTIVE;
    cnt_inc     = 1'b0;
    cnt_clr     = 1'b1;

    case (state_q)
      IDLE, T3: begin
        state_d = IDLE;
        if (bus_grant) begin
          state_d = BUSACK;
        end else if (handshake) begin
          state_d    = T1;
          write_d    = req_in.write;
          bus_addr_d = req_in.addr;
          if (req_in.write) begin
            bus_dout_d = req_in.wdata;
          end
        end
      end
      T1:      state_d = T2;
      T2:      state_d = wait_n ? T3 : TW;
      TW:      if (wait_n || cnt_timeout) state_d = T3;
      BUSACK:  if (bus_release) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Completion edge: capture read data; err only when the timeout forced the exit.
    if ((state_q == T2 || state_q == TW) && state_d == T3) begin
      if (!write_q) begin
        rsp_rdata_d = bus_din;
      end
      rsp_err_d = (state_q == TW) && !wait_n;
    end

    case (state_d)
      IDLE: req_ready_d = accept_ok;
      T1: begin
        mreq_n_d  = 1'b0;
        rd_n_d    = write_d;
        bus_doe_d = write_d;
      end
      T2, TW: begin
        mreq_n_d  = 1'b0;
        rd_n_d    = write_d;
        wr_n_d    = !write_d;
        bus_doe_d = write_d;
      end
      T3: begin
        bus_doe_d   = write_d;
        rsp_valid_d = 1'b1;
        req_ready_d = accept_ok;
      end
      default: ;
    endcase

    cnt_inc = (state_d == TW);
    cnt_clr = !cnt_inc;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      write_q     <= 1'b0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      bus_addr_q  <= '0;
      bus_dout_q  <= '0;
      bus_doe_q   <= 1'b0;
      mreq_n_q    <= STROBE_INACTIVE;
      rd_n_q      <= STROBE_INACTIVE;
      wr_n_q      <= STROBE_INACTIVE;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      bus_addr_q  <= bus_addr_d;
      bus_dout_q  <= bus_dout_d;
      bus_doe_q   <= bus_doe_d;
      mreq_n_q    <= mreq_n_d;
      rd_n_q      <= rd_n_d;
      wr_n_q      <= wr_n_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign bus_addr  = bus_addr_q;
  assign bus_dout  = bus_dout_q;
  assign bus_doe   = bus_doe_q;
  assign mreq_n    = mreq_n_q;
  assign rd_n      = rd_n_q;
  assign wr_n      = wr_n_q;

endmodule

// File: doc/z80_mem_cycle_seq.md
Name: z80_mem_cycle_seq

Overview:
Sequences Z80 memory M-cycles (read and write) on the external bus for the core's execution unit, e.g. the single write cycle of LD (HL),n to address HL. It accepts one request at a time, drives T1/T2/TW/T3 strobes with WAIT insertion, and returns read data or write completion. It is the sole owner of the external memory bus between the core and memory.

Parameters:
- MAX_WAIT, 255, TW states tolerated per cycle before the cycle is forced to complete with err=1. 0 disables the timeout.

Ports:
- clk  in  1  system clock; one T-state per clk cycle
- reset  in  1  synchronous, active-high
- req_valid  in  1  request pending
- req_ready  out  1  sequencer accepts request this cycle
- req_write  in  1  1=memory write, 0=memory read
- req_addr  in  16  memory address (e.g. HL)
- req_wdata  in  8  write data (e.g. immediate n)
- rsp_valid  out  1  one-cycle pulse: cycle complete
- rsp_rdata  out  8  read data, valid with rsp_valid for reads
- rsp_err  out  1  wait timeout occurred, valid with rsp_valid
- bus_addr  out  16  address bus
- bus_dout  out  8  data bus out
- bus_doe  out  1  data bus output enable
- bus_din  in  8  data bus in
- mreq_n  out  1  memory request, active low
- rd_n  out  1  read strobe, active low
- wr_n  out  1  write strobe, active low
- wait_n  in  1  memory wait, active low

Behaviour:
- All outputs registered. Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, bus_addr=0, bus_dout=0, bus_doe=0, mreq_n=1, rd_n=1, wr_n=1; state=IDLE; wait counter=0.
- Reset wins over any in-flight cycle: strobes return high on the next edge, and no rsp_valid is produced for the aborted request.
- States: IDLE, T1, T2, TW, T3.
- req_ready=1 in IDLE and T3. A handshake is req_valid&&req_ready; it latches addr, wdata, write and moves to T1.
- IDLE: no handshake -> stay in IDLE.
- T1: bus_addr=latched addr; mreq_n=0; rd_n=0 if read. For a write, bus_dout=wdata and bus_doe=1. -> T2.
- T2: wr_n=0 if write; strobes are held. wait_n sampled at the end of T2: 1 -> T3; 0 -> TW.
- TW: strobes held and counter incremented. wait_n=1, or counter==MAX_WAIT with MAX_WAIT!=0 -> T3 (err set if timeout); else stay in TW.
- Read data: bus_din is captured into rsp_rdata on the edge leaving T2/TW.
- T3: mreq_n, rd_n and wr_n deasserted. bus_doe stays 1 through T3 for writes, then drops. rsp_valid=1 for exactly this cycle.
  - Handshake in T3 -> T1 (back-to-back, no idle gap).
  - No handshake -> IDLE.
- Minimum latency is 3 cycles from T1 to rsp_valid (T1, T2, T3), plus one per TW.
- wait_n is ignored outside T2/TW.
- req_* inputs are ignored when req_ready=0.
- bus_addr holds its last value in IDLE.

Optional Feature:
- Z80_SEQ_BUSREQ_EN adds two ports: busreq_n (in) and busack_n (out, reset 1), plus a BUSACK state.
- With the macro defined:
  - busreq_n=0 is sampled in IDLE or T3. It takes priority over a new request, so req_ready=0 in that cycle.
  - The next state is BUSACK. In BUSACK: busack_n=0, bus_doe=0, strobes high, req_ready=0.
  - BUSACK is left for IDLE one cycle after busreq_n returns to 1.
  - An in-progress cycle is never interrupted.
- Without the macro: no BUSACK state and no extra ports.

Decomposition:
- Shared package z80_bus_pkg holds:
  - enum tstate_t {IDLE,T1,T2,TW,T3,BUSACK}
  - typedef bus_req_t {write, addr[15:0], wdata[7:0]}
  - the strobe inactive constant
- One sub-module, z80_wait_counter: counter with clear/increment/timeout flag, parameterised by MAX_WAIT.

Test Plan:
- Write, no wait: req write addr=16'h8000 wdata=8'h5A.
  - T1: bus_addr=8000, mreq_n=0, bus_doe=1, bus_dout=5A.
  - T2: wr_n=0.
  - T3: strobes high, rsp_valid=1 at cycle 3.
- Read with 2 waits: addr=16'h1234, wait_n=0 for two T2/TW samples, bus_din=8'hC3 on release.
  - Exactly 2 TW cycles.
  - rsp_valid at cycle 5 with rsp_rdata=C3.
- Back-to-back: second request presented in T3 of the first.
  - T1 follows T3 directly.
  - mreq_n goes high for exactly the T3 cycle only.
- Timeout: MAX_WAIT=4, wait_n held 0.
  - 4 TW cycles, then T3 with rsp_err=1 and strobes released.
- Reset mid-cycle: assert reset during TW.
  - Next cycle all strobes=1, state IDLE.
  - No rsp_valid; a new request then completes normally.
- (Z80_SEQ_BUSREQ_EN) busreq_n=0 during a read.
  - Read completes.
  - BUSACK entered after T3: busack_n=0, bus_doe=0.
  - After busreq_n=1, BUSACK releases within 1 cycle.
